hazard_ctrl: RTL

- Pipeline sequencing controller for the 5-stage RV32 core.
- Sits beside the forwarding logic and decides per cycle which pipeline registers hold, which get a bubble, and when the multi-cycle mul/div unit (MDU) is started.
- Handles four hazard classes: data-memory wait, MDU busy, taken-branch redirect and load-use.
- Also provides an MDU watchdog.

---
 rtl/riscv_pkg.sv | 37 +++
 rtl/hazard_watchdog.sv | 37 +++
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 core types used by the pipeline hazard controller.
package riscv_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hazard_state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam int unsigned MDU_TIMEOUT_DEFAULT = 64;

    // x0 never creates a dependency, so a load targeting it cannot stall.
    function automatic logic load_use_hit(
        input logic      mem_read,
        input reg_addr_t ex_rd,
        input logic      uses_rs1,
        input reg_addr_t rs1,
        input logic      uses_rs2,
        input reg_addr_t rs2
    );
        return mem_read && (ex_rd != '0) &&
               ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/hazard_watchdog.sv
// MDU watchdog: down-counter loaded at MDU start, terminal count at zero,
// sticky error flop set when a busy cycle lands on terminal count.
module hazard_watchdog #(
    parameter int unsigned MDU_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic tc,
    output logic err
);

    localparam int unsigned CW = $clog2(MDU_TIMEOUT);
    localparam logic [CW-1:0] TC_LOAD = CW'(MDU_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    assign tc = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (load) begin
                cnt <= TC_LOAD;
            end else if (advance && !tc) begin
                cnt <= cnt - 1'b1;
            end
            if (advance && tc) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage RV32 core with MDU watchdog.
// Define HAZARD_PERF_CNT_EN to add saturating hazard performance counters.
//
// state    | meaning
// RUN      | normal issue; MDU start, branch and load-use hazards evaluated
// MDU_BUSY | MDU instruction held in EX until done or watchdog expiry
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  reg_addr_t        id_rs1,
    input  reg_addr_t        id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  reg_addr_t        id_ex_rd,
    input  logic             id_ex_mem_read,
    input  logic             id_ex_is_mdu,
    input  logic             mdu_done,
    input  logic             branch_taken_ex,
    input  logic             ex_mem_dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             ex_mem_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mdu_start,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] perf_load_use_cnt,
    output logic [CNT_W-1:0] perf_mdu_stall_cnt,
    output logic [CNT_W-1:0] perf_mem_wait_cnt,
`endif
    output logic             mdu_timeout_err
);

    if (MDU_TIMEOUT < 2) begin : g_bad_timeout
        $error("hazard_ctrl: MDU_TIMEOUT must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be >= 1");
    end

    hazard_state_e state_q, state_d;
    logic          done_pend_q, done_pend_d;
    pipe_ctrl_t    ctrl;
    logic          start_c;

    logic mem_wait, load_use, busy, done_any;
    logic r_mdu_start, r_mdu_wait, r_mdu_timeout, r_mdu_done, r_branch, r_load_use;
    logic wd_tc, wd_err;

    assign mem_wait = ex_mem_dmem_req & ~dmem_ready;
    assign load_use = load_use_hit(id_ex_mem_read, id_ex_rd, id_uses_rs1, id_rs1,
                                   id_uses_rs2, id_rs2);
    assign busy     = (state_q == MDU_BUSY);
    assign done_any = mdu_done | done_pend_q;

    // One-hot rule decode in priority order; mem_wait pre-empts everything.
    assign r_mdu_start   = ~mem_wait & ~busy & id_ex_is_mdu;
    assign r_mdu_wait    = ~mem_wait &  busy & ~done_any & ~wd_tc;
    assign r_mdu_timeout = ~mem_wait &  busy & ~done_any &  wd_tc;
    assign r_mdu_done    = ~mem_wait &  busy &  done_any;
    assign r_branch      = ~mem_wait & ~busy & ~id_ex_is_mdu & branch_taken_ex;
    assign r_load_use    = ~mem_wait & ~busy & ~id_ex_is_mdu & ~branch_taken_ex & load_use;

    hazard_watchdog #(
        .MDU_TIMEOUT(MDU_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .load    (r_mdu_start),
        .advance (r_mdu_wait | r_mdu_timeout),
        .tc      (wd_tc),
        .err     (wd_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            done_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_pend_q <= done_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        if (r_mdu_start) begin
            state_d = MDU_BUSY;
        end
        if (r_mdu_done || r_mdu_timeout) begin
            state_d     = RUN;
            done_pend_d = 1'b0;
        end
        // A done pulse hidden behind a memory wait must not be lost.
        if (mem_wait && busy && mdu_done) begin
            done_pend_d = 1'b1;
        end
    end

    always_comb begin
        ctrl    = '0;
        start_c = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_stall = 1'b1;
                ctrl.mem_wb_flush = 1'b1;
            end else if (r_mdu_start || r_mdu_wait) begin
                start_c           = r_mdu_start;
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_stall  = 1'b1;
                ctrl.ex_mem_flush = 1'b1;
            end else if (r_branch) begin
                ctrl.if_id_flush  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
            end else if (r_load_use) begin
                ctrl.pc_stall     = 1'b1;
                ctrl.if_id_stall  = 1'b1;
                ctrl.id_ex_flush  = 1'b1;
            end
        end
    end

    assign pc_stall        = ctrl.pc_stall;
    assign if_id_stall     = ctrl.if_id_stall;
    assign id_ex_stall     = ctrl.id_ex_stall;
    assign ex_mem_stall    = ctrl.ex_mem_stall;
    assign if_id_flush     = ctrl.if_id_flush;
    assign id_ex_flush     = ctrl.id_ex_flush;
    assign ex_mem_flush    = ctrl.ex_mem_flush;
    assign mem_wb_flush    = ctrl.mem_wb_flush;
    assign mdu_start       = start_c;
    assign mdu_timeout_err = wd_err & ~rst;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_use_cnt  <= '0;
            perf_mdu_stall_cnt <= '0;
            perf_mem_wait_cnt  <= '0;
        end else begin
            if (r_load_use && !(&perf_load_use_cnt)) begin
                perf_load_use_cnt <= perf_load_use_cnt + 1'b1;
            end
            if ((r_mdu_start || r_mdu_wait) && !(&perf_mdu_stall_cnt)) begin
                perf_mdu_stall_cnt <= perf_mdu_stall_cnt + 1'b1;
            end
            if (mem_wait && !(&perf_mem_wait_cnt)) begin
                perf_mem_wait_cnt <= perf_mem_wait_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
